// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Width helpers shared by the flagged synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A two-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DATA_W x DEPTH register array, one write port, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [PTR_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with any depth, fill count, threshold flags,
//               sticky error flags and selectable FWFT / registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         pop_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      overflow_o,
    output logic                      underflow_o,
    input  logic                      clr_err_i
);

    localparam int c_cnt_w = cnt_w(DEPTH);
    localparam int c_ptr_w = ptr_w(DEPTH);

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_cnt   = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0] c_ae_cnt   = c_cnt_w'(AE_THRESH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_full;
    logic               r_empty;
    logic               r_af;
    logic               r_ae;
    logic               r_ovf;
    logic               r_unf;
    logic               w_push_acc;
    logic               w_pop_acc;
    logic [DATA_W-1:0]  w_rd_data;

    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign w_pop_acc  = pop_i & ~r_empty;
    assign w_push_acc = push_i & (~r_full | w_pop_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_acc && !w_pop_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_acc && w_pop_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_cnt);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= c_af_cnt);
            r_ae    <= (w_count_nxt <= c_ae_cnt);
            // A fresh error in the same cycle as a clear keeps the flag set.
            if (push_i && !w_push_acc) begin
                r_ovf <= 1'b1;
            end else if (clr_err_i) begin
                r_ovf <= 1'b0;
            end
            if (pop_i && !w_pop_acc) begin
                r_unf <= 1'b1;
            end else if (clr_err_i) begin
                r_unf <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (c_ptr_w)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (push_data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign pop_data_o = r_empty ? '0 : w_rd_data;
        end else begin : g_reg_read
            logic [DATA_W-1:0] r_pop_data;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pop_data <= '0;
                end else if (w_pop_acc) begin
                    r_pop_data <= w_rd_data;
                end
            end
            assign pop_data_o = r_pop_data;
        end
    endgenerate

    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_af;
    assign almost_empty_o = r_ae;
    assign count_o        = r_count;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;

endmodule
`default_nettype wire
